// File: rtl/axi2ahb_ahb_ctrl_pkg.sv
// Shared AHB encodings, FSM state type and burst mapping for the AXI-to-AHB
// master control stage.
package axi2ahb_ahb_ctrl_pkg;

    localparam int unsigned LEN_BITS  = 4;
    localparam int unsigned SIZE_BITS = 2;
    localparam int unsigned CNT_BITS  = 5;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_FIN  = 2'b10
    } state_e;

    // Burst attributes held stable for the whole AHB burst
    typedef struct packed {
        hburst_e    burst;
        logic [2:0] size;
        logic       write;
    } ahb_ctrl_t;

    // Only lengths 0/3/7/15 reach the bus; anything else is rejected upstream
    function automatic hburst_e burst_of(input logic [LEN_BITS-1:0] len);
        hburst_e b;
        case (len)
            4'd0:    b = HBURST_SINGLE;
            4'd3:    b = HBURST_INCR4;
            4'd7:    b = HBURST_INCR8;
            4'd15:   b = HBURST_INCR16;
            default: b = HBURST_INCR;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/axi2ahb_ahb_ctrl_if.sv
// Command-queue head, AHB master and data-path completion signals of the
// AHB control stage.
interface axi2ahb_ahb_ctrl_if #(
    parameter int unsigned ADDR_BITS = 32
);
    logic                 cmd_empty;
    logic                 cmd_read;
    logic [ADDR_BITS-1:0] cmd_addr;
    logic [3:0]           cmd_len;
    logic [1:0]           cmd_size;
    logic                 cmd_err;
    logic                 wdata_rdy;
    logic                 rdata_room;

    logic [ADDR_BITS-1:0] HADDR;
    logic [2:0]           HBURST;
    logic [2:0]           HSIZE;
    logic [1:0]           HTRANS;
    logic                 HWRITE;
    logic                 HREADY;
    logic [1:0]           HRESP;

    logic                 data_beat;
    logic                 data_last;
    logic                 ahb_finish;
    logic                 finish_err;

    modport master (
        input  cmd_empty, cmd_read, cmd_addr, cmd_len, cmd_size, cmd_err,
        input  wdata_rdy, rdata_room,
        output HADDR, HBURST, HSIZE, HTRANS, HWRITE,
        input  HREADY, HRESP,
        output data_beat, data_last, ahb_finish, finish_err
    );

    modport slave (
        output cmd_empty, cmd_read, cmd_addr, cmd_len, cmd_size, cmd_err,
        output wdata_rdy, rdata_room,
        input  HADDR, HBURST, HSIZE, HTRANS, HWRITE,
        output HREADY, HRESP,
        input  data_beat, data_last, ahb_finish, finish_err
    );
endinterface

// File: rtl/axi2ahb_ahb_beat_cnt.sv
// Address/data beat counters and address incrementer for one AHB burst.
// addr is the address of the beat currently presented on the bus.
module axi2ahb_ahb_beat_cnt
    import axi2ahb_ahb_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [ADDR_BITS-1:0] start_addr,
    input  logic [LEN_BITS-1:0]  len,
    input  logic [SIZE_BITS-1:0] size,
    input  logic                 addr_acc,
    input  logic                 data_done,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 more_addr_c,
    output logic                 dphase_c,
    output logic                 last_data_c
);

    logic [ADDR_BITS-1:0] addr_q;
    logic [CNT_BITS-1:0]  acnt_q;
    logic [CNT_BITS-1:0]  dcnt_q;
    logic [LEN_BITS-1:0]  len_q;
    logic [SIZE_BITS-1:0] size_q;
    logic [ADDR_BITS-1:0] incr_c;

    assign incr_c = ADDR_BITS'(1) << size_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            acnt_q <= '0;
            dcnt_q <= '0;
            len_q  <= '0;
            size_q <= '0;
        end else if (load) begin
            addr_q <= start_addr;
            acnt_q <= '0;
            dcnt_q <= '0;
            len_q  <= len;
            size_q <= size;
        end else begin
            if (addr_acc) begin
                addr_q <= addr_q + incr_c;
                acnt_q <= acnt_q + CNT_BITS'(1);
            end
            if (data_done) begin
                dcnt_q <= dcnt_q + CNT_BITS'(1);
            end
        end
    end

    // Beats accepted but not yet completed are in their data phase
    assign addr        = addr_q;
    assign more_addr_c = acnt_q < CNT_BITS'(len_q);
    assign dphase_c    = acnt_q != dcnt_q;
    assign last_data_c = dcnt_q == CNT_BITS'(len_q);

endmodule

// File: rtl/axi2ahb_ahb_ctrl.sv
// AHB master control stage: turns the command-queue head into an AHB burst,
// reports data-phase completion and pops the queue when done.
module axi2ahb_ahb_ctrl
    import axi2ahb_ahb_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 32
) (
    input  logic              clk,
    input  logic              reset,
    axi2ahb_ahb_ctrl_if.master bus
);

    state_e    state_q, state_d;
    htrans_e   htrans_q, htrans_d;
    ahb_ctrl_t ctrl_q, ctrl_d;
    logic      beat_q, beat_d;
    logic      last_q, last_d;
    logic      fin_q, fin_d;
    logic      ferr_q, ferr_d;
    logic      err_q, err_d;

    logic      load_c;
    logic      addr_acc_c;
    logic      data_done_c;
    logic      cmd_go_c;
    logic      hresp_err_c;
    logic      more_addr_c;
    logic      dphase_c;
    logic      last_data_c;
    logic [ADDR_BITS-1:0] addr;

    axi2ahb_ahb_beat_cnt #(
        .ADDR_BITS (ADDR_BITS)
    ) u_beat_cnt (
        .clk         (clk),
        .reset       (reset),
        .load        (load_c),
        .start_addr  (bus.cmd_addr),
        .len         (bus.cmd_len),
        .size        (bus.cmd_size),
        .addr_acc    (addr_acc_c),
        .data_done   (data_done_c),
        .addr        (addr),
        .more_addr_c (more_addr_c),
        .dphase_c    (dphase_c),
        .last_data_c (last_data_c)
    );

    // The whole burst must be buffered before the first address phase, so BUSY is never needed
    assign cmd_go_c    = !bus.cmd_empty && !bus.cmd_err &&
                         (bus.cmd_read ? bus.rdata_room : bus.wdata_rdy);
    assign hresp_err_c = bus.HRESP == HRESP_ERROR;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            htrans_q <= HTRANS_IDLE;
            ctrl_q   <= '0;
            beat_q   <= 1'b0;
            last_q   <= 1'b0;
            fin_q    <= 1'b0;
            ferr_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            htrans_q <= htrans_d;
            ctrl_q   <= ctrl_d;
            beat_q   <= beat_d;
            last_q   <= last_d;
            fin_q    <= fin_d;
            ferr_q   <= ferr_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        htrans_d    = htrans_q;
        ctrl_d      = ctrl_q;
        beat_d      = 1'b0;
        last_d      = 1'b0;
        fin_d       = 1'b0;
        ferr_d      = 1'b0;
        err_d       = err_q;
        load_c      = 1'b0;
        addr_acc_c  = 1'b0;
        data_done_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                htrans_d = HTRANS_IDLE;
                if (!bus.cmd_empty && bus.cmd_err) begin
                    state_d = ST_FIN;
                    fin_d   = 1'b1;
                    ferr_d  = 1'b1;
                end else if (cmd_go_c) begin
                    state_d      = ST_BUS;
                    load_c       = 1'b1;
                    htrans_d     = HTRANS_NONSEQ;
                    ctrl_d.burst = burst_of(bus.cmd_len);
                    ctrl_d.size  = {1'b0, bus.cmd_size};
                    ctrl_d.write = !bus.cmd_read;
                end
            end

            ST_BUS: begin
                if (bus.HREADY) begin
                    if (dphase_c && (err_q || hresp_err_c)) begin
                        // Second ERROR cycle: abandon the burst without a data beat
                        state_d  = ST_FIN;
                        htrans_d = HTRANS_IDLE;
                        fin_d    = 1'b1;
                        ferr_d   = 1'b1;
                    end else begin
                        if (htrans_q == HTRANS_NONSEQ || htrans_q == HTRANS_SEQ) begin
                            addr_acc_c = 1'b1;
                            htrans_d   = more_addr_c ? HTRANS_SEQ : HTRANS_IDLE;
                        end
                        if (dphase_c) begin
                            data_done_c = 1'b1;
                            beat_d      = 1'b1;
                            if (last_data_c) begin
                                last_d  = 1'b1;
                                state_d = ST_FIN;
                                fin_d   = 1'b1;
                            end
                        end
                    end
                end else if (dphase_c && hresp_err_c) begin
                    // First ERROR cycle: cancel the pending address phase
                    err_d    = 1'b1;
                    htrans_d = HTRANS_IDLE;
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end

            default: begin
                state_d  = ST_IDLE;
                htrans_d = HTRANS_IDLE;
            end
        endcase
    end

    assign bus.HADDR      = addr;
    assign bus.HTRANS     = htrans_q;
    assign bus.HBURST     = ctrl_q.burst;
    assign bus.HSIZE      = ctrl_q.size;
    assign bus.HWRITE     = ctrl_q.write;
    assign bus.data_beat  = beat_q;
    assign bus.data_last  = last_q;
    assign bus.ahb_finish = fin_q;
    assign bus.finish_err = ferr_q;

endmodule

// File: doc/axi2ahb_ahb_ctrl.md
# axi2ahb_ahb_ctrl

AHB master control stage of the AXI-to-AHB bridge. Consumes the head entry of the bridge command queue (arbitrated AW/AR commands), issues the matching AHB burst (NONSEQ/SEQ address phases, pipelined against data phases), reports per-beat data-phase completion to the data path, and pulses `ahb_finish` to pop the queue when the burst, or the rejected command, is done.

## Interface
- `ADDR_BITS`, 32, AXI/AHB address width.
- `clk` in 1: clock, all logic on posedge.
- `reset` in 1: asynchronous, active-high.
- `cmd_empty` in 1: command queue empty.
- `cmd_read` in 1: head command is a read.
- `cmd_addr` in ADDR_BITS: head start address.
- `cmd_len` in 4: AXI beats-1; always 0, 3, 7 or 15 when `cmd_err`=0.
- `cmd_size` in 2: log2 bytes per beat.
- `cmd_err` in 1: head command illegal for AHB (bad length or unaligned).
- `wdata_rdy` in 1: write buffer holds the whole head burst.
- `rdata_room` in 1: read buffer has room for the whole head burst.
- `HADDR` out ADDR_BITS; `HBURST` out 3; `HSIZE` out 3; `HTRANS` out 2; `HWRITE` out 1.
- `HREADY` in 1; `HRESP` in 2.
- `data_beat` out 1: a data phase completed this cycle (HREADY=1 in data phase).
- `data_last` out 1: qualifies `data_beat` as the final beat.
- `ahb_finish` out 1: one-cycle pulse; pops the command queue.
- `finish_err` out 1: valid with `ahb_finish`; command rejected or AHB ERROR seen.

## Operation
- All outputs registered; reset values: HTRANS=IDLE(00), HADDR=0, HBURST=0, HSIZE=0, HWRITE=0, data_beat=0, data_last=0, ahb_finish=0, finish_err=0.
- States: IDLE, BUS, FIN.
- IDLE: if `!cmd_empty & cmd_err` -> FIN with finish_err=1, no AHB traffic. If `!cmd_empty & !cmd_err & (cmd_read ? rdata_room : wdata_rdy)` -> BUS, load addr/len/size counters, drive NONSEQ.
- Burst map: len 0->SINGLE 000, 3->INCR4 011, 7->INCR8 101, 15->INCR16 111. HSIZE={0,cmd_size}. HWRITE=~cmd_read.
- BUS: beat counter `acnt` (address phases issued) and `dcnt` (data phases done). Address advances by 1<<size on each accepted address phase (HREADY=1), full ADDR_BITS add; no 1KB-boundary check here. SEQ for beats 2..N, then HTRANS=IDLE. Never drives BUSY (whole burst prebuffered).
- Data phase completion: `data_beat`=1 each cycle HREADY=1 in a data phase; `data_last` on beat len+1; then -> FIN.
- HRESP=ERROR (first cycle, HREADY=0): drive HTRANS=IDLE next cycle, cancel remaining beats, set sticky error, -> FIN after the second ERROR cycle; no further `data_beat`.
- FIN: pulse `ahb_finish` (+`finish_err`), clear sticky error, -> IDLE. One-cycle FIN guarantees the popped head is not re-sampled.
- Reset mid-burst: immediate return to IDLE, HTRANS=IDLE; queue content is reset by its own reset.

## Timing
- Queue non-empty and resources ready at cycle T -> NONSEQ on HTRANS at T+1.
- Zero-wait burst of N beats: address phases T+1..T+N, data phases T+2..T+N+1, `data_last` at T+N+1 output register -> visible T+N+2, `ahb_finish` T+N+2... exact: `ahb_finish` asserted the cycle after the last data phase completes.
- Wait states (HREADY=0) hold HADDR/HTRANS/HBURST and counters stable.
- Error command: `ahb_finish` at T+1; next command earliest NONSEQ at T+3.
- Back-to-back bursts: minimum one HTRANS=IDLE cycle between bursts (FIN + IDLE).

## Structure
- Shared package: HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), HBURST codes, HRESP codes, state encoding.
- One natural sub-module: `axi2ahb_ahb_beat_cnt` (address/data beat counters + address incrementer).

## Test plan
- Single read, len=0, size=2, addr 0x100, zero wait -> one NONSEQ HBURST=000 HSIZE=010 HWRITE=0, one data_beat with data_last, ahb_finish, finish_err=0.
- INCR8 write, addr 0x200, size=2, wdata_rdy=1 -> NONSEQ then 7 SEQ, HADDR 0x200..0x21C step 4, 8 data_beats, finish 1 cycle after 8th.
- INCR4 with HREADY=0 for 3 cycles on beat 2 -> all bus outputs frozen, 4 beats total, finish delayed by 3.
- cmd_err=1 head -> no HTRANS activity, ahb_finish+finish_err at T+1, next valid command proceeds.
- INCR16 read, ERROR response on beat 5 -> HTRANS=IDLE after first ERROR cycle, 4 data_beats, finish_err=1.
- Write head with wdata_rdy=0 for 10 cycles -> HTRANS stays IDLE until wdata_rdy rises; reset asserted mid-INCR8 -> HTRANS=IDLE, ahb_finish=0 immediately.
